// File: rtl/frame_capture.sv
// frame_capture: trigger-qualified ADC frame acquisition.
// Arms on run, waits for a level/slope crossing, writes SAMPLES consecutive
// valid samples into data[], then freezes the frame for HOLD_CYCLES cycles.
// Optional timeout auto-trigger: define FRAME_CAPTURE_AUTO_TRIG_EN.
module frame_capture #(
    parameter int unsigned SAMPLES     = 512,
    parameter int unsigned HOLD_CYCLES = 1_000_000,
    parameter int unsigned TIMEOUT     = 50_000_000,
    localparam int unsigned DATA_W     = 12
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_W-1:0]               adc_data,
    input  logic                            adc_valid,
    input  logic [DATA_W-1:0]               trig_level,
    input  logic                            trig_falling,
    input  logic                            run,
    output logic [0:SAMPLES-1][DATA_W-1:0]  data,
    output logic                            frame_valid,
    output logic                            frame_done,
    output logic                            auto_trig,
    output logic                            busy,
    output logic [7:0]                      frame_count
);

    localparam int unsigned IDX_W  = $clog2(SAMPLES);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [DATA_W-1:0] MID_SCALE = DATA_W'(2048);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(SAMPLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    // Reject illegal configurations at elaboration.
    if (SAMPLES < 2 || SAMPLES > 4095) begin : g_bad_samples
        $error("frame_capture: SAMPLES out of range 2..4095");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("frame_capture: HOLD_CYCLES must be at least 1");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("frame_capture: TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    wr_idx_q;
    logic [DATA_W-1:0]   prev_q;
    logic                prev_ok_q;
    logic [HOLD_W-1:0]   hold_cnt_q;

    logic                edge_hit;
    logic                to_expired;
    logic                wr_en;
    logic [IDX_W-1:0]    wr_addr;
    logic                trig_fire;
    logic                arm_entry;
    logic                hold_entry;

    // Slope/level crossing against the previous valid sample (unsigned).
    assign edge_hit = prev_ok_q && (trig_falling
                      ? ((prev_q > trig_level) && (adc_data <= trig_level))
                      : ((prev_q < trig_level) && (adc_data >= trig_level)));

    assign arm_entry  = (state_d == ARMED) && (state_q != ARMED);
    assign hold_entry = (state_d == HOLD)  && (state_q != HOLD);

`ifdef FRAME_CAPTURE_AUTO_TRIG_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT);

    logic [TO_W-1:0] to_cnt_q;

    assign to_expired = (to_cnt_q == TO_LAST);

    // ARMED dwell counter; saturates at TIMEOUT until the forced trigger.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_q <= '0;
        end else if (arm_entry) begin
            to_cnt_q <= '0;
        end else if ((state_q == ARMED) && !to_expired) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end

    // Records whether the current frame was started by the timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            auto_trig <= 1'b0;
        end else if (trig_fire) begin
            auto_trig <= !edge_hit;
        end
    end
`else
    assign to_expired = 1'b0;
    assign auto_trig  = 1'b0;
`endif

    // Next-state and write-strobe decode.
    always_comb begin
        state_d   = state_q;
        wr_en     = 1'b0;
        wr_addr   = '0;
        trig_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (!run) begin
                    state_d = IDLE;
                end else if (adc_valid && (edge_hit || to_expired)) begin
                    state_d   = CAPTURE;
                    wr_en     = 1'b1;
                    wr_addr   = '0;
                    trig_fire = 1'b1;
                end
            end
            CAPTURE: begin
                if (adc_valid) begin
                    wr_en   = 1'b1;
                    wr_addr = wr_idx_q;
                    if (wr_idx_q == LAST_IDX) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = run ? ARMED : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame write pointer; next slot after data[0] on trigger.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_idx_q <= '0;
        end else if (wr_en) begin
            wr_idx_q <= (wr_addr == LAST_IDX) ? '0 : wr_addr + IDX_W'(1);
        end
    end

    // Previous valid sample for crossing detection; invalidated on arming.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q    <= '0;
            prev_ok_q <= 1'b0;
        end else if (arm_entry) begin
            prev_ok_q <= 1'b0;
        end else if ((state_q == ARMED) && adc_valid) begin
            prev_q    <= adc_data;
            prev_ok_q <= 1'b1;
        end
    end

    // HOLD dwell counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt_q <= '0;
        end else if ((state_q == HOLD) && (state_d == HOLD)) begin
            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
        end else begin
            hold_cnt_q <= '0;
        end
    end

    // Frame storage; only the trigger cycle and CAPTURE write it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data <= {SAMPLES{MID_SCALE}};
        end else if (wr_en) begin
            data[wr_addr] <= adc_data;
        end
    end

    // Registered status outputs derived from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_valid <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_valid <= (state_d == HOLD);
            frame_done  <= hold_entry;
            busy        <= (state_d == ARMED) || (state_d == CAPTURE);
            if (hold_entry) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule
